// File: rtl/tdm_pkg.sv
// Shared definitions for the select-scanned TDM link (receiver and future transmitter).
// TDM_DEMUX_PARITY_EN adds a trailing even-parity slot to every frame.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int NCH_DEFAULT = 8;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int PARITY_SLOTS = 1;
`else
  localparam int PARITY_SLOTS = 0;
`endif

  localparam int FRAME_LEN_DEFAULT = NCH_DEFAULT + PARITY_SLOTS;

  // Slots per frame for a given channel count, including any parity slot.
  function automatic int frame_len(input int nch);
    return nch + PARITY_SLOTS;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Wrapping slot counter 0..LEN-1 with enable, load-to-1 and clear; flags the last slot.
// Priority: clr over load1 over en.
module tdm_slot_ctr #(
  parameter int LEN = 8,
  parameter int W   = $clog2(LEN)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load1,
  input  logic         clr,
  output logic [W-1:0] slot,
  output logic         last
);

  localparam logic [W-1:0] LAST_IDX = W'(LEN - 1);

  assign last = (slot == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= W'(1);
    end else if (en) begin
      slot <= last ? '0 : slot + W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux8.sv
// Receive-side framer for the 8:1 select-scanned serial link: tracks slots, rebuilds the word.
// TDM_DEMUX_PARITY_EN: frame carries an extra even-parity slot and parity_err is driven.
//
// Handshake: a beat is consumed on every rising edge with din_valid=1; there is no
// backpressure. out_valid, sync_err and parity_err are single-cycle registered pulses,
// visible the cycle after the beat that caused them; data changes only with out_valid.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter  int NCH = NCH_DEFAULT,
  localparam int SW  = $clog2(NCH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           din,
  input  logic           din_valid,
  input  logic           sync,
  output logic [NCH-1:0] data,
  output logic           out_valid,
  output logic           locked,
  output logic [SW-1:0]  slot,
  output logic           sync_err,
  output logic           parity_err
);

  localparam int FLEN = frame_len(NCH);
  // Bits held before the final beat of a frame; the final beat is used directly.
  localparam int SHW  = FLEN - 1;

  state_t           state, state_d;
  logic [SHW-1:0]   shadow;
  logic [SW-1:0]    wr_idx;
  logic [NCH-1:0]   frame_word;
  logic             last;
  logic             ctr_en, ctr_load1, ctr_clr;
  logic             shadow_we, frame_done, err_d;

  tdm_slot_ctr #(
    .LEN (FLEN),
    .W   (SW)
  ) u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .en    (ctr_en),
    .load1 (ctr_load1),
    .clr   (ctr_clr),
    .slot  (slot),
    .last  (last)
  );

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    ctr_en     = 1'b0;
    ctr_load1  = 1'b0;
    ctr_clr    = 1'b0;
    shadow_we  = 1'b0;
    wr_idx     = '0;
    frame_done = 1'b0;
    err_d      = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (sync) begin
            state_d   = LOCKED;
            ctr_load1 = 1'b1;
            shadow_we = 1'b1;
          end
        end
        LOCKED: begin
          if (sync && slot != '0) begin
            // Early sync restarts the frame on this beat.
            err_d     = 1'b1;
            ctr_load1 = 1'b1;
            shadow_we = 1'b1;
          end else if (!sync && slot == '0) begin
            err_d   = 1'b1;
            state_d = HUNT;
            ctr_clr = 1'b1;
          end else begin
            ctr_en = 1'b1;
            if (last) begin
              frame_done = 1'b1;
            end else begin
              shadow_we = 1'b1;
              wr_idx    = slot;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic parity_q;

  assign frame_word = shadow;
  assign parity_err = parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= frame_done & ((^shadow) ^ din);
  end
`else
  assign frame_word = {din, shadow};
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      data      <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= frame_done;
      sync_err  <= err_d;
      if (frame_done) data <= frame_word;
      for (int i = 0; i < SHW; i++) begin
        if (shadow_we && wr_idx == SW'(i)) shadow[i] <= din;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux8.sv
// Randomized scoreboard bench for tdm_demux8 against a queue-based frame model.
// Honors TDM_DEMUX_PARITY_EN the same way as the design.
module tb_tdm_demux8;

  localparam int NCH = 8;
  localparam int SW  = $clog2(NCH + 1);
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FLEN = NCH + 1;
`else
  localparam int FLEN = NCH;
`endif
  localparam int EW = NCH + 2;  // {is_sync_err, parity_err, data}

  logic           clk;
  logic           rst;
  logic           din;
  logic           din_valid;
  logic           sync;
  logic [NCH-1:0] data;
  logic           out_valid;
  logic           locked;
  logic [SW-1:0]  slot;
  logic           sync_err;
  logic           parity_err;

  tdm_demux8 #(.NCH(NCH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .sync       (sync),
    .data       (data),
    .out_valid  (out_valid),
    .locked     (locked),
    .slot       (slot),
    .sync_err   (sync_err),
    .parity_err (parity_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int             tests = 0;
  int             fails = 0;
  logic [EW-1:0]  exp_q[$];

  // Reference model: bits of the frame in progress, lock flag, last delivered word.
  logic           m_bits[$];
  bit             m_locked;
  logic [NCH-1:0] m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_locked = 1'b0;
    m_data   = '0;
    exp_q.delete();
  endtask

  task automatic model_beat(input logic d, input logic s);
    logic [NCH-1:0] w;
    logic           p;
    if (!m_locked) begin
      if (s) begin
        m_bits.delete();
        m_bits.push_back(d);
        m_locked = 1'b1;
      end
    end else if (s && m_bits.size() != 0) begin
      exp_q.push_back({1'b1, 1'b0, m_data});
      m_bits.delete();
      m_bits.push_back(d);
    end else if (!s && m_bits.size() == 0) begin
      exp_q.push_back({1'b1, 1'b0, m_data});
      m_locked = 1'b0;
    end else begin
      m_bits.push_back(d);
      if (m_bits.size() == FLEN) begin
        w = '0;
        p = 1'b0;
        for (int i = 0; i < NCH; i++) w[i] = m_bits[i];
`ifdef TDM_DEMUX_PARITY_EN
        for (int i = 0; i < FLEN; i++) p = p ^ m_bits[i];
`endif
        m_data = w;
        exp_q.push_back({1'b0, p, w});
        m_bits.delete();
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic beat(input logic d, input logic s, input int gap);
    @(negedge clk);
    din_valid = 1'b1;
    din       = d;
    sync      = s;
    @(posedge clk);
    model_beat(d, s);
    repeat (gap) begin
      @(negedge clk);
      din_valid = 1'b0;
      din       = 1'($urandom);
      sync      = 1'($urandom);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [NCH-1:0] w, input int gap, input bit flip);
    for (int i = 0; i < NCH; i++) beat(w[i], i == 0, gap);
`ifdef TDM_DEMUX_PARITY_EN
    beat((^w) ^ flip, 1'b0, gap);
`else
    if (flip) idle(0);
`endif
  endtask

  // Next negedge for directed checks; input goes idle at the same time.
  task automatic settle();
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    din_valid = 1'b0;
    #1;
    check("rst_data", data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_slot", slot, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_parity_err", parity_err, 0);
    model_reset();
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid || sync_err) begin
          check("pulse_overlap", out_valid & sync_err, 0);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse: got out_valid=%0b sync_err=%0b expected none at %0t",
                     out_valid, sync_err, $time);
          end else begin
            e = exp_q.pop_front();
            check("pulse_kind", sync_err, e[EW-1]);
            check("pulse_parity_err", parity_err, e[EW-2]);
            check("pulse_data", data, e[NCH-1:0]);
          end
        end else begin
          check("missing_pulse", exp_q.size(), 0);
          exp_q.delete();
          check("stray_parity_err", parity_err, 0);
        end
        check("data_hold", data, m_data);
        check("locked", locked, m_locked);
        check("slot", slot, m_locked ? m_bits.size() : 0);
      end
    end
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int k, g, n;
    rst       = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    sync      = 1'b0;
    model_reset();
    do_reset();

    // Reset mid-frame, then beats without sync are ignored until a fresh sync.
    for (int i = 0; i < 3; i++) beat(1'b1, i == 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 0);
    settle();
    check("post_rst_locked", locked, 0);

    // Single frame 0xA5 (parity bit 1 when the parity slot exists).
    send_frame(8'hA5, 0, 1'b1);
    settle();
    check("a5_data", data, 8'hA5);
    check("a5_valid", out_valid, 1);
    check("a5_locked", locked, 1);
`ifdef TDM_DEMUX_PARITY_EN
    check("a5_parity_err", parity_err, 1);
    send_frame(8'hA5, 0, 1'b0);
    settle();
    check("a5_good_parity", parity_err, 0);
    check("a5_good_data", data, 8'hA5);
`endif

    // Back-to-back frames.
    send_frame(8'h81, 0, 1'b0);
    send_frame(8'h7E, 0, 1'b0);
    settle();
    check("b2b_data", data, 8'h7E);

    // Gapped beats.
    send_frame(8'h3C, 2, 1'b0);
    idle(2);
    settle();
    check("gap_data", data, 8'h3C);

    // Early sync at slot 5, then a full 0xFF frame starting on that beat.
    for (int i = 0; i < 5; i++) beat(1'b0, i == 0, 0);
    send_frame(8'hFF, 0, 1'b0);
    settle();
    check("early_data", data, 8'hFF);
    check("early_locked", locked, 1);

    // Missing sync after a completed frame.
    send_frame(8'h12, 0, 1'b0);
    beat(1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 1);
    settle();
    check("miss_data", data, 8'h12);
    check("miss_locked", locked, 0);

    // Randomized traffic.
    for (int it = 0; it < 300; it++) begin
      k = $urandom_range(0, 9);
      g = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 3);
      if (k < 6) begin
        send_frame(NCH'($urandom), g, $urandom_range(0, 3) == 0);
      end else if (k < 8) begin
        n = $urandom_range(1, FLEN - 1);
        for (int i = 0; i < n; i++) beat(1'($urandom), i == 0, g);
      end else if (k < 9) begin
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) beat(1'($urandom), $urandom_range(0, 3) == 0, g);
      end else if ($urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        idle($urandom_range(1, 5));
      end
    end

    idle(3);
    settle();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
